adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/adder_arbiter.sv | 126 ++++++++++++
 tb/tb_adder_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter block.
//   DEFAULT_NREQ / DEFAULT_WIDTH : default requester count and operand width
//   reg_state_e                  : result register occupancy (EMPTY / FULL)
//   id_width()                   : bits needed to index NREQ requesters
package adder_arb_pkg;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } reg_state_e;

  // Never narrower than one bit, so a degenerate count still gives a legal vector.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection.
//   req   [NREQ]  : request vector (one bit per requester)
//   ptr   [PTR_W] : index searched first; search proceeds upward with wrap
//   en            : when low no grant is issued
//   grant [NREQ]  : one-hot grant, all zeros if disabled or nothing requested
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant
);

  int               pos;
  logic [PTR_W-1:0] pos_idx;
  logic             found;

  // Walk the requesters starting at ptr; the first requesting one wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      pos_idx = pos[PTR_W-1:0];
      if (en && !found && (pos < NREQ) && req[pos_idx]) begin
        grant[pos_idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shared adder with round-robin access for NREQ requesters and a one-deep
// result register.
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (at most one ready bit)
//   req_a/req_b           : packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid/res_ready   : result handshake
//   res_sum/res_carry/res_ovf : A+B mod 2^WIDTH, unsigned carry, signed overflow
//   res_id                : requester that owns the current result
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_sum,
  output logic                    res_carry,
  output logic                    res_ovf,
  output logic [$clog2(NREQ)-1:0] res_id
);

  localparam int IDW = id_width(NREQ);

  reg_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [NREQ-1:0]  grant;
  logic             arb_en;
  logic             accept;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   sum_ext;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Accepting is possible when the register is free or is being drained this
  // cycle. rst_n is folded in so no grant is ever shown during reset.
  assign arb_en = rst_n && ((state_q == EMPTY) || res_ready);

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .en    (arb_en),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

  assign sel_a   = op_a[grant_idx];
  assign sel_b   = op_b[grant_idx];
  assign sum_ext = {1'b0, sel_a} + {1'b0, sel_b};

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    id_d     = id_q;
    if (accept) begin
      state_d = FULL;
      if (int'(grant_idx) == NREQ - 1) rr_ptr_d = '0;
      else                             rr_ptr_d = grant_idx + 1'b1;
      sum_d   = sum_ext[WIDTH-1:0];
      carry_d = sum_ext[WIDTH];
      // Overflow: like-signed operands producing a result of the other sign.
      ovf_d   = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) &&
                (sum_ext[WIDTH-1] != sel_a[WIDTH-1]);
      id_d    = grant_idx;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_ovf   = ovf_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised scoreboard bench for adder_arbiter (NREQ=4, WIDTH=32).
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_carry;
  logic                  res_ovf;
  logic [IDW-1:0]        res_id;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_id    (res_id)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic [IDW-1:0]   id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: pending requests, result-register occupancy, RR pointer.
  bit               tv [NREQ];
  logic [WIDTH-1:0] ta [NREQ];
  logic [WIDTH-1:0] tb [NREQ];
  bit               t_res_ready;
  int               m_ptr;
  bit               m_full;
  bit               use_fixed;
  exp_t             fixed_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Reference arithmetic with wide integers instead of bit tricks.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int id);
    exp_t   e;
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(a);
    ub = longint'(b);
    us = ua + ub;
    sa = (a[WIDTH-1]) ? ua - (longint'(1) << WIDTH) : ua;
    sb = (b[WIDTH-1]) ? ub - (longint'(1) << WIDTH) : ub;
    ss = sa + sb;
    e.sum   = us[WIDTH-1:0];
    e.carry = (us >= (longint'(1) << WIDTH));
    e.ovf   = (ss >= (longint'(1) << (WIDTH-1))) || (ss < -(longint'(1) << (WIDTH-1)));
    e.id    = IDW'(id);
    return e;
  endfunction

  function automatic int expect_grant();
    if (m_full && !t_res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (tv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = tv[i];
      req_a[i*WIDTH +: WIDTH]   = ta[i];
      req_b[i*WIDTH +: WIDTH]   = tb[i];
    end
    res_ready = t_res_ready;
  endtask

  // One clock: drive at posedge+2, check at the negedge, update the model for
  // the coming edge, return at next posedge+2. g_obs is the DUT's granted index.
  task automatic step(output int g_obs);
    int              g;
    logic [NREQ-1:0] want;
    apply();
    @(negedge clk);
    g     = expect_grant();
    want  = (g < 0) ? '0 : NREQ'(1 << g);
    g_obs = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g_obs = i;
    check("req_ready", req_ready, want);
    check("res_valid", res_valid, m_full);
    if (g >= 0) begin
      exp_q.push_back(use_fixed ? fixed_exp : model(ta[g], tb[g], g));
      $display("accept id=%0d a=%h b=%h", g, ta[g], tb[g]);
      tv[g]  = 0;
      m_ptr  = (g + 1) % NREQ;
      m_full = 1;
    end else if (t_res_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: any presented result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("res_valid_unexpected", res_valid, 0);
      end else begin
        check("res_sum", res_sum, exp_q[0].sum);
        check("res_carry", res_carry, exp_q[0].carry);
        check("res_ovf", res_ovf, exp_q[0].ovf);
        check("res_id", res_id, exp_q[0].id);
        if (res_ready) begin
          $display("result id=%0d sum=%h carry=%0b ovf=%0b", res_id, res_sum, res_carry, res_ovf);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } flag_vec_t;

  flag_vec_t flag_tab [3];
  int        fair_seq [5];
  int        g_obs;

  initial begin
    flag_tab[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    flag_tab[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    flag_tab[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    fair_seq    = '{0, 1, 2, 3, 0};

    for (int i = 0; i < NREQ; i++) begin
      tv[i] = 0; ta[i] = '0; tb[i] = '0;
    end
    t_res_ready = 0; m_ptr = 0; m_full = 0; use_fixed = 0;
    rst_n = 1'b1;
    apply();
    #1 rst_n = 1'b0;
    #1;
    check("reset_res_valid", res_valid, 0);
    check("reset_res_sum", res_sum, 0);
    check("reset_res_id", res_id, 0);
    tv[0] = 1; t_res_ready = 1; apply();
    #1 check("reset_req_ready", req_ready, 0);
    tv[0] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request from requester 2.
    tv[2] = 1; ta[2] = 32'h5; tb[2] = 32'h6; t_res_ready = 1;
    use_fixed = 1; fixed_exp = '{32'h0000_000B, 1'b0, 1'b0, 2'd2};
    step(g_obs);
    check("single_grant", g_obs, 2);
    use_fixed = 0;
    step(g_obs);

    // Arithmetic flag corners through requester 0.
    for (int k = 0; k < 3; k++) begin
      tv[0] = 1; ta[0] = flag_tab[k].a; tb[0] = flag_tab[k].b;
      use_fixed = 1;
      fixed_exp = '{flag_tab[k].sum, flag_tab[k].carry, flag_tab[k].ovf, 2'd0};
      step(g_obs);
      use_fixed = 0;
    end
    step(g_obs);

    // Move pointer back to 0, then all four contend.
    tv[3] = 1; ta[3] = rand_op(); tb[3] = rand_op();
    step(g_obs);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREQ; i++) if (!tv[i]) begin
        tv[i] = 1; ta[i] = rand_op(); tb[i] = rand_op();
      end
      step(g_obs);
      check("fair_order", g_obs, fair_seq[k]);
    end

    // Backpressure: hold FULL for five cycles, then release.
    t_res_ready = 0;
    for (int k = 0; k < 5; k++) begin
      step(g_obs);
      check("bp_no_grant", g_obs, -1);
    end
    t_res_ready = 1;
    step(g_obs);
    check("bp_release_grant", g_obs, 1);

    // Drain, then set pointer to 3 with a held result and reset mid-flight.
    for (int i = 0; i < NREQ; i++) tv[i] = 0;
    step(g_obs);
    tv[2] = 1; ta[2] = rand_op(); tb[2] = rand_op();
    step(g_obs);
    t_res_ready = 0;
    step(g_obs);
    tv[1] = 1; tv[3] = 1; t_res_ready = 1; apply();
    #1 rst_n = 1'b0;
    #1;
    check("midreset_res_valid", res_valid, 0);
    check("midreset_req_ready", req_ready, 0);
    check("midreset_res_sum", res_sum, 0);
    exp_q.delete();
    m_ptr = 0; m_full = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(g_obs);
    check("post_reset_grant", g_obs, 1);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) if (!tv[i] && $urandom_range(0, 2) == 0) begin
        tv[i] = 1; ta[i] = rand_op(); tb[i] = rand_op();
      end
      t_res_ready = ($urandom_range(0, 3) != 0);
      step(g_obs);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < NREQ; i++) tv[i] = 0;
    t_res_ready = 1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || m_full); c++) step(g_obs);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
